// File: rtl/hazard_sequencer.sv
// hazard_sequencer
// ----------------
// Pipeline hazard controller for a classic five-stage core. Every cycle it
// decides whether the pipeline advances, freezes behind a slow data memory,
// squashes wrong-path instructions after a control redirect, or inserts a
// single bubble for a load-use dependency.
//
// Decision priority: memory busy > redirect > load-use. Stage enables and
// flushes are combinational from the current inputs so the decision takes
// effect in the same cycle.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> cnt_flush / cnt_lu / cnt_memwait are live 32-bit wrapping counters
//   undefined -> the three counter outputs are constant 0 and no counter flops exist
//
// Ports
//   clk              in   pipeline clock
//   rst_n            in   asynchronous active-low reset
//   pc_src[1:0]      in   EX redirect code (00 none, 01 branch/jal, 10 jalr, 11 illegal)
//   memread_ex       in   EX instruction is a load
//   rd_ex[4:0]       in   EX destination register
//   rs1_id[4:0]      in   ID source register 1
//   rs2_id[4:0]      in   ID source register 2
//   dmem_req         in   MEM-stage data access pending
//   dmem_ready       in   data memory completes this cycle
//   pc_we            out  PC write enable
//   ifid_we          out  IF/ID write enable
//   idex_we          out  ID/EX write enable
//   exmem_we         out  EX/MEM write enable
//   ifid_flush       out  bubble into IF/ID
//   idex_flush       out  bubble into ID/EX
//   err_illegal_src  out  sticky: pc_src=11 was seen
//   err_mem_timeout  out  sticky: memory wait reached MEM_TIMEOUT cycles
//   cnt_flush[31:0]  out  redirect cycles taken
//   cnt_lu[31:0]     out  load-use stall cycles
//   cnt_memwait[31:0] out busy (frozen) cycles
//
// Parameter
//   MEM_TIMEOUT      consecutive wait cycles after which err_mem_timeout sets

module hazard_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pc_src,
  input  logic        memread_ex,
  input  logic [4:0]  rd_ex,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_we,
  output logic        exmem_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        err_illegal_src,
  output logic        err_mem_timeout,
  output logic [31:0] cnt_flush,
  output logic [31:0] cnt_lu,
  output logic [31:0] cnt_memwait
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    LU_STALL = 2'd2,
    MEM_WAIT = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_ill_q, err_ill_d;
  logic       err_to_q, err_to_d;

  logic busy;
  logic redirect;
  logic load_use;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  always_comb begin
    busy     = dmem_req & ~dmem_ready;
    redirect = (pc_src != 2'b00);
    load_use = memread_ex & (rd_ex != 5'd0) & ((rd_ex == rs1_id) | (rd_ex == rs2_id));
  end

  // Outputs and next state depend only on the current triggers; FLUSH and
  // LU_STALL therefore fall back to RUN on their own unless a fresh trigger
  // is present. While reset is held the pipeline is frozen with bubbles.
  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    idex_we    = 1'b1;
    exmem_we   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_d    = RUN;
    if (!rst_n) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_we    = 1'b0;
      exmem_we   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
    end else if (busy) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_we    = 1'b0;
      exmem_we   = 1'b0;
      state_d    = MEM_WAIT;
    end else if (redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = FLUSH;
    end else if (load_use) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
      state_d    = LU_STALL;
    end
  end

  // The wait counter tracks the length of the current freeze. The first busy
  // cycle arrives from a non-wait state and starts the run at one; the count
  // saturates so a stuck memory cannot wrap it back below the threshold.
  always_comb begin
    wait_cnt_d = 8'd0;
    if (busy) begin
      if (state_q == MEM_WAIT) begin
        wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
      end else begin
        wait_cnt_d = 8'd1;
      end
    end
    err_ill_d = err_ill_q | (pc_src == 2'b11);
    err_to_d  = err_to_q | (busy & (32'(wait_cnt_d) >= MEM_TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      err_ill_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_ill_q  <= err_ill_d;
      err_to_q   <= err_to_d;
    end
  end

  assign err_illegal_src = err_ill_q;
  assign err_mem_timeout = err_to_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] cnt_flush_q, cnt_lu_q, cnt_memwait_q;

  // Each counter follows the action actually taken this cycle, so a redirect
  // or load-use hidden behind a memory freeze is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_flush_q   <= 32'd0;
      cnt_lu_q      <= 32'd0;
      cnt_memwait_q <= 32'd0;
    end else begin
      if (busy) begin
        cnt_memwait_q <= cnt_memwait_q + 32'd1;
      end
      if (!busy && redirect) begin
        cnt_flush_q <= cnt_flush_q + 32'd1;
      end
      if (!busy && !redirect && load_use) begin
        cnt_lu_q <= cnt_lu_q + 32'd1;
      end
    end
  end

  assign cnt_flush   = cnt_flush_q;
  assign cnt_lu      = cnt_lu_q;
  assign cnt_memwait = cnt_memwait_q;
`else
  assign cnt_flush   = 32'd0;
  assign cnt_lu      = 32'd0;
  assign cnt_memwait = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Testbench for hazard_sequencer (instantiated with MEM_TIMEOUT=4).
// Stimulus is issued just after each rising edge; the expected response for
// that cycle is pushed into a scoreboard queue and a separate monitor pops
// and compares it on the following falling edge.

module tb_hazard_sequencer;

  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic        memread_ex = 1'b0;
  logic [4:0]  rd_ex = 5'd0;
  logic [4:0]  rs1_id = 5'd0;
  logic [4:0]  rs2_id = 5'd0;
  logic        dmem_req = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        pc_we, ifid_we, idex_we, exmem_we;
  logic        ifid_flush, idex_flush;
  logic        err_illegal_src, err_mem_timeout;
  logic [31:0] cnt_flush, cnt_lu, cnt_memwait;

  hazard_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_src          (pc_src),
    .memread_ex      (memread_ex),
    .rd_ex           (rd_ex),
    .rs1_id          (rs1_id),
    .rs2_id          (rs2_id),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_we           (pc_we),
    .ifid_we         (ifid_we),
    .idex_we         (idex_we),
    .exmem_we        (exmem_we),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .err_illegal_src (err_illegal_src),
    .err_mem_timeout (err_mem_timeout),
    .cnt_flush       (cnt_flush),
    .cnt_lu          (cnt_lu),
    .cnt_memwait     (cnt_memwait)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cycle;
    logic [7:0]  ctl;
    logic [95:0] cnt;
  } exp_t;

  exp_t scoreQ[$];
  int   testCount = 0;
  int   failCount = 0;
  int   cycleNum = 0;
  bit   stimDone = 1'b0;
  bit   monitorDone = 1'b0;

  // Reference state: what the sticky flags, current freeze length and the
  // three event tallies should be at the start of the present cycle.
  bit          mErrIll = 1'b0;
  bit          mErrTo = 1'b0;
  int          mRunLen = 0;
  logic [31:0] mFlush = 32'd0;
  logic [31:0] mLu = 32'd0;
  logic [31:0] mWait = 32'd0;

  // Drive one cycle of inputs, predict the response, then advance the model.
  task automatic applyStimulus(input bit rst, input logic [1:0] ps, input bit mr,
                               input logic [4:0] rd, input logic [4:0] r1,
                               input logic [4:0] r2, input bit req, input bit rdy);
    bit         isBusy, isRedir, isLu;
    logic [5:0] act;
    exp_t       e;
    @(posedge clk);
    #1;
    rst_n = rst; pc_src = ps; memread_ex = mr; rd_ex = rd;
    rs1_id = r1; rs2_id = r2; dmem_req = req; dmem_ready = rdy;
    cycleNum++;
    isBusy  = req && !rdy;
    isRedir = (ps != 2'b00);
    isLu    = mr && (rd != 5'd0) && (rd == r1 || rd == r2);
    if (!rst) begin
      mErrIll = 0; mErrTo = 0; mRunLen = 0;
      mFlush = 0; mLu = 0; mWait = 0;
      act = 6'b0000_11;
    end else if (isBusy)  act = 6'b0000_00;
    else if (isRedir)     act = 6'b1111_11;
    else if (isLu)        act = 6'b0011_01;
    else                  act = 6'b1111_00;
    e.cycle = cycleNum;
    e.ctl   = {act, mErrIll, mErrTo};
`ifdef HAZARD_PERF_CNT_EN
    e.cnt   = {mFlush, mLu, mWait};
`else
    e.cnt   = 96'd0;
`endif
    scoreQ.push_back(e);
    if (rst) begin
      if (ps == 2'b11) mErrIll = 1;
      if (isBusy) begin
        mRunLen = (mRunLen >= 255) ? 255 : mRunLen + 1;
        if (mRunLen >= int'(TIMEOUT)) mErrTo = 1;
        mWait = mWait + 1;
      end else begin
        mRunLen = 0;
        if (isRedir) mFlush = mFlush + 1;
        else if (isLu) mLu = mLu + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [7:0]  ctl;
    logic [95:0] cnt;
    ctl = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
           err_illegal_src, err_mem_timeout};
    cnt = {cnt_flush, cnt_lu, cnt_memwait};
    testCount++;
    if (ctl !== e.ctl) begin
      failCount++;
      $display("[TB] FAIL ctl cycle %0d: got %b expected %b (pc,ifid,idex,exmem,fIfid,fIdex,eIll,eTo)",
               e.cycle, ctl, e.ctl);
    end
    testCount++;
    if (cnt !== e.cnt) begin
      failCount++;
      $display("[TB] FAIL counters cycle %0d: got %h expected %h (flush,lu,memwait)",
               e.cycle, cnt, e.cnt);
    end
  endtask

  // Monitor: one response per cycle, compared away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (scoreQ.size() > 0) begin
        checkOutput(scoreQ.pop_front());
      end else if (stimDone) begin
        monitorDone = 1'b1;
      end
    end
  end

  initial begin
    // Reset state.
    applyStimulus(0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    applyStimulus(0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(1);
    // Single branch redirect then normal flow.
    applyStimulus(1, 2'b01, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(2);
    // Load-use on rs2, then the same with rd=x0 and all sources x0.
    applyStimulus(1, 2'b00, 1, 5'd5, 5'd1, 5'd5, 0, 0);
    idle(1);
    applyStimulus(1, 2'b00, 1, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(1);
    // Three-cycle memory wait.
    for (int i = 0; i < 3; i++) applyStimulus(1, 2'b00, 0, 5'd0, 5'd0, 5'd0, 1, 0);
    applyStimulus(1, 2'b00, 0, 5'd0, 5'd0, 5'd0, 1, 1);
    idle(1);
    // Busy masks jalr and load-use; on ready the redirect wins.
    applyStimulus(1, 2'b10, 1, 5'd7, 5'd7, 5'd2, 1, 0);
    applyStimulus(1, 2'b10, 1, 5'd7, 5'd7, 5'd2, 1, 1);
    idle(1);
    // Six-cycle wait crosses the timeout; illegal redirect code afterwards.
    for (int i = 0; i < 6; i++) applyStimulus(1, 2'b00, 0, 5'd0, 5'd0, 5'd0, 1, 0);
    applyStimulus(1, 2'b00, 0, 5'd0, 5'd0, 5'd0, 1, 1);
    applyStimulus(1, 2'b11, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(2);
    // Reset in the middle of a wait, then a redirect right after release.
    for (int i = 0; i < 2; i++) applyStimulus(1, 2'b00, 0, 5'd0, 5'd0, 5'd0, 1, 0);
    applyStimulus(0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 1, 0);
    applyStimulus(0, 2'b01, 0, 5'd0, 5'd0, 5'd0, 1, 0);
    applyStimulus(1, 2'b01, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(1);
    // Randomized traffic with small register numbers so hazards are common.
    for (int i = 0; i < 600; i++) begin
      bit         r, mr, req, rdy;
      logic [1:0] ps;
      r   = ($urandom_range(0, 149) != 0);
      ps  = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
      mr  = ($urandom_range(0, 1) == 1);
      req = ($urandom_range(0, 9) < 4);
      rdy = ($urandom_range(0, 3) == 0);
      applyStimulus(r, ps, mr, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), req, rdy);
    end
    idle(2);
    stimDone = 1'b1;
    for (int i = 0; i < 50 && !monitorDone; i++) @(posedge clk);
    if (!monitorDone) begin
      $display("[TB] FAIL drain: scoreboard not emptied, %0d entries left", scoreQ.size());
      $fatal(1, "[TB] scoreboard drain bound expired");
    end
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
